// File: rtl/bht_pkg.sv
// Shared constants for the 2-bit branch-history counter table:
// geometry, default counter value, FSM encodings and saturation limits.
package bht_pkg;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int CTR_W   = 2;

  localparam logic [CTR_W-1:0] RESET_STATE_DFLT = 2'b01;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_INIT = 1'b1;

  localparam logic [CTR_W-1:0] CTR_MAX = 2'b11;
  localparam logic [CTR_W-1:0] CTR_MIN = 2'b00;

endpackage

// File: rtl/bht_counter_table_if.sv
// Resolved-branch update channel from execute into the counter table.
interface bht_counter_table_if;
  import bht_pkg::*;

  logic             upd_valid;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_index;
  logic             upd_taken;

  modport master (output upd_valid, output upd_index, output upd_taken, input upd_ready);
  modport slave  (input upd_valid, input upd_index, input upd_taken, output upd_ready);

endinterface

// File: rtl/sat_ctr2_next.sv
// Combinational saturating step of a 2-bit direction counter; no wrap-around.
module sat_ctr2_next
  import bht_pkg::*;
(
  input  logic [CTR_W-1:0] i_old,
  input  logic             i_taken,
  output logic [CTR_W-1:0] o_next
);

  always_comb begin
    o_next = i_old;
    if (i_taken) begin
      if (i_old != CTR_MAX) o_next = i_old + 2'd1;
    end else begin
      if (i_old != CTR_MIN) o_next = i_old - 2'd1;
    end
  end

endmodule

// File: rtl/bht_counter_table.sv
// 16-entry 2-bit saturating branch counter table with one-cycle update stage and clear sweep.
// Optional statistics counters are enabled by defining BHT_STATS_EN.
module bht_counter_table
  import bht_pkg::*;
#(
  parameter logic [CTR_W-1:0] RESET_STATE = RESET_STATE_DFLT
)(
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  bht_counter_table_if.slave       upd,
  output logic [ENTRIES*CTR_W-1:0] ctr_all,
  output logic                     busy
`ifdef BHT_STATS_EN
  ,
  output logic [15:0]              upd_count,
  output logic [15:0]              misp_count
`endif
);

  logic [0:0]               r_state;
  logic [IDX_W-1:0]         r_sweep_idx;
  logic [ENTRIES*CTR_W-1:0] r_ctr_all;
  logic                     r_upd_vld;
  logic [IDX_W-1:0]         r_upd_idx;
  logic                     r_upd_taken;
  logic [CTR_W-1:0]         w_old;
  logic [CTR_W-1:0]         w_next;
  logic                     w_ready;

  assign w_ready       = (r_state == ST_RUN) && !clear;
  assign upd.upd_ready = w_ready;
  assign ctr_all       = r_ctr_all;
  assign busy          = (r_state == ST_INIT);

  // The stage reads the registered table, so the previous stage's write is already visible.
  assign w_old = r_ctr_all[{r_upd_idx, 1'b0} +: CTR_W];

  sat_ctr2_next u_sat (
    .i_old   (w_old),
    .i_taken (r_upd_taken),
    .o_next  (w_next)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_sweep_idx <= '0;
      r_ctr_all   <= {ENTRIES{RESET_STATE}};
      r_upd_vld   <= 1'b0;
      r_upd_idx   <= '0;
      r_upd_taken <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (clear) begin
        // A pending update write is dropped when the sweep starts.
        r_state     <= ST_INIT;
        r_sweep_idx <= '0;
        r_upd_vld   <= 1'b0;
      end else begin
        if (r_upd_vld) r_ctr_all[{r_upd_idx, 1'b0} +: CTR_W] <= w_next;
        r_upd_vld <= upd.upd_valid;
        if (upd.upd_valid) begin
          r_upd_idx   <= upd.upd_index;
          r_upd_taken <= upd.upd_taken;
        end
      end
    end else begin
      r_ctr_all[{r_sweep_idx, 1'b0} +: CTR_W] <= RESET_STATE;
      r_sweep_idx <= r_sweep_idx + IDX_W'(1);
      if (r_sweep_idx == IDX_W'(ENTRIES - 1)) r_state <= ST_RUN;
    end
  end

`ifdef BHT_STATS_EN
  logic [15:0] r_upd_count;
  logic [15:0] r_misp_count;

  assign upd_count  = r_upd_count;
  assign misp_count = r_misp_count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_upd_count  <= '0;
      r_misp_count <= '0;
    end else if (r_state == ST_RUN) begin
      if (clear) begin
        r_upd_count  <= '0;
        r_misp_count <= '0;
      end else if (r_upd_vld) begin
        if (r_upd_count != 16'hFFFF) r_upd_count <= r_upd_count + 16'd1;
        if ((w_old[1] != r_upd_taken) && (r_misp_count != 16'hFFFF))
          r_misp_count <= r_misp_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/bht_counter_table.md
Name: bht_counter_table

Overview:
- 16-entry table of 2-bit saturating branch-direction counters.
- Sits directly upstream of the 16:1 2-bit read mux.
  - Presents all 16 counters in parallel on a flat bus; the mux selects one by PC index.
  - Lets fetch read the counter as ctr[1] = predict taken.
- Accepts resolved-branch updates from execute through a valid/ready handshake and a one-cycle update stage.
- Supports a multi-cycle clear sweep.

Parameters:
- RESET_STATE, 2'b01, counter value loaded by reset and by clear sweep (weakly not-taken).
- ENTRIES, 16, entry count; fixed at 16 to match the downstream mux.
- IDX_W, 4, index width, log2(ENTRIES).

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- clear  in  1  one-cycle pulse; starts clear sweep.
- upd_valid  in  1  update request from execute.
- upd_ready  out  1  table can accept update this cycle.
- upd_index  in  4  entry to update.
- upd_taken  in  1  resolved direction, 1 = taken.
- ctr_all  out  32  all counters; entry i on bits [2i+1:2i]; feeds mux in0..in15.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (reset_n=0 at rising edge):
  - all entries = RESET_STATE; state = RUN; sweep index = 0; update stage invalid.
  - busy=0; ctr_all = {16{RESET_STATE}}.
- States:
  - RUN: normal operation.
  - INIT: clear sweep.
- RUN -> INIT on clear=1. The sweep index is loaded with 0 on that edge.
- INIT behaviour:
  - Each cycle writes RESET_STATE to entry[sweep index], then increments the index.
  - After the write of entry 15: index wraps to 0 and state -> RUN.
  - busy=1 for exactly 16 cycles.
  - Unswept entries keep old values on ctr_all.
- clear while in INIT: ignored; the sweep continues and is not restarted.
- upd_ready = (state==RUN) && !clear; purely combinational.
- Handshake: an update is accepted on a rising edge with upd_valid && upd_ready. Index and taken are captured into the update stage.
  - Upstream holds upd_valid/index/taken stable until accepted.
- Update stage, the cycle after acceptance:
  - Computes next = sat(entry[idx], taken) from the current table contents.
  - Writes the result at the end of that cycle.
  - ctr_all reflects the update 2 edges after acceptance.
- Saturation:
  - taken: 00->01->10->11, 11 holds.
  - not taken: 11->10->01->00, 00 holds.
  - No wrap-around.
- Back-to-back updates: one per cycle, any indices including the same one.
  - No hazard: each stage reads the table after the previous write.
  - Example: same index twice taken from 01 gives 10, then 11.
- clear while the update stage is valid: the pending write is dropped and the sweep starts. Update-stage valid clears on the same edge.
- reset_n=0 mid-sweep or with an update pending: everything returns to reset values on that edge. No partial writes.
- ctr_all is a direct register output with no combinational path from inputs.

Optional Feature:
- Macro: BHT_STATS_EN.
- Defined:
  - Adds outputs upd_count[15:0] and misp_count[15:0], both reset to 0 and zeroed by clear.
  - upd_count increments once per update-stage write.
  - misp_count increments when the stage's old entry[idx][1] != taken.
  - Both saturate at 16'hFFFF.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package bht_pkg:
  - ENTRIES, IDX_W, CTR_W=2.
  - RESET_STATE default.
  - State encodings RUN / INIT.
  - Saturation limits CTR_MAX=2'b11, CTR_MIN=2'b00.
- Sub-module sat_ctr2_next: combinational (old[1:0], taken) -> next[1:0] saturating step.
  - Used by the update stage.
  - Reusable by other predictors.

Test Plan:
- Reset: hold reset_n=0 two cycles, release -> ctr_all=32'h5555_5555, busy=0, upd_ready=1.
- Update entry 3 taken three times back-to-back from reset -> entry 3 goes 10 then 11 then holds 11. Other bits unchanged.
  - Final ctr_all[7:6]=2'b11.
- Update entry 15 not-taken twice from 01 -> 00, stays 00; ctr_all[31:30]=2'b00.
  - Under BHT_STATS_EN: misp_count=0, upd_count=2.
- Set entries 0 and 9 to 11, pulse clear with an update pending on entry 9:
  - busy=1 for exactly 16 cycles; upd_ready=0 throughout.
  - entry 9 ends 01, with no late write.
  - ctr_all=32'h5555_5555 after the sweep.
- Assert reset_n=0 at sweep cycle 7 -> next cycle busy=0, state RUN, all entries 01.
- upd_valid held high with clear asserted the same cycle -> update not accepted. It is accepted once upd_ready returns, after the 16-cycle sweep.
